// File: rtl/hyperterm_recv.sv
// HyperTerminal receive path: 8N1 UART deserialiser, hex-text word parser and one-entry output stream.
// Optional byte echo on tx is built when HYPERTERM_RECV_ECHO_EN is defined.
module hyperterm_recv #(
  parameter int unsigned BIT_DIV = 20000
) (
  input  logic        clk_48,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_err,
  output logic        hex_err,
  output logic        overrun
);

  localparam logic [15:0] DIV_LAST  = 16'(BIT_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'((BIT_DIV / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------- synchroniser
  logic [2:0] sync_chain;
  logic       rx_s;

  assign sync_chain[0] = rx;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic stage_reg;
      always_ff @(posedge clk_48) begin
        if (rst) stage_reg <= 1'b1;
        else     stage_reg <= sync_chain[gi];
      end
      assign sync_chain[gi+1] = stage_reg;
    end
  endgenerate

  assign rx_s = sync_chain[2];

  // ---------------------------------------------------------------- bit FSM
  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        byte_done;
  logic        frame_bad;

  always_ff @(posedge clk_48) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 16'd0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'd0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    byte_done    = 1'b0;
    frame_bad    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          cnt_next   = 16'd0;
        end
      end
      S_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next     = 16'd0;
          bit_idx_next = 3'd0;
          state_next   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next     = 16'd0;
          shift_next   = {rx_s, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = S_STOP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = 16'd0;
          if (rx_s) begin
            byte_done  = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = S_WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- hex parser
  logic [2:0]  digit_reg, digit_next;
  logic [15:0] acc_reg, acc_next;
  logic        bad_reg, bad_next;
  logic [3:0]  nib;
  logic        is_hex;
  logic        is_delim;
  logic        emit;
  logic        tok_err;

  always_comb begin
    nib    = 4'h0;
    is_hex = 1'b0;
    if (shift_reg >= 8'h30 && shift_reg <= 8'h39) begin
      is_hex = 1'b1;
      nib    = shift_reg[3:0];
    end else if ((shift_reg >= 8'h41 && shift_reg <= 8'h46) ||
                 (shift_reg >= 8'h61 && shift_reg <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = shift_reg[3:0] + 4'd9;
    end
    is_delim = (shift_reg == 8'h20) || (shift_reg == 8'h0D) || (shift_reg == 8'h0A);
  end

  // bad_reg marks a token already reported, so its delimiter stays silent
  always_comb begin
    digit_next = digit_reg;
    acc_next   = acc_reg;
    bad_next   = bad_reg;
    emit       = 1'b0;
    tok_err    = 1'b0;
    if (byte_done) begin
      if (is_hex) begin
        acc_next   = {acc_reg[11:0], nib};
        digit_next = (digit_reg == 3'd5) ? 3'd5 : digit_reg + 3'd1;
      end else if (is_delim) begin
        digit_next = 3'd0;
        bad_next   = 1'b0;
        if (digit_reg == 3'd4)                  emit    = 1'b1;
        else if (digit_reg != 3'd0 && !bad_reg) tok_err = 1'b1;
      end else begin
        tok_err    = 1'b1;
        bad_next   = 1'b1;
        digit_next = 3'd5;
      end
    end
  end

  always_ff @(posedge clk_48) begin
    if (rst) begin
      digit_reg <= 3'd0;
      acc_reg   <= 16'd0;
      bad_reg   <= 1'b0;
    end else begin
      digit_reg <= digit_next;
      acc_reg   <= acc_next;
      bad_reg   <= bad_next;
    end
  end

  // ---------------------------------------------------------------- output holding register
  logic [15:0] word_reg;
  logic        word_valid_reg;
  logic        frame_err_reg;
  logic        hex_err_reg;
  logic        overrun_reg;

  always_ff @(posedge clk_48) begin
    if (rst) begin
      word_reg       <= 16'd0;
      word_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      hex_err_reg    <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      frame_err_reg <= frame_bad;
      hex_err_reg   <= tok_err;
      overrun_reg   <= 1'b0;
      if (emit) begin
        if (!word_valid_reg || word_ready) begin
          word_reg       <= acc_reg;
          word_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (word_valid_reg && word_ready) begin
        word_valid_reg <= 1'b0;
      end
    end
  end

  assign word       = word_reg;
  assign word_valid = word_valid_reg;
  assign frame_err  = frame_err_reg;
  assign hex_err    = hex_err_reg;
  assign overrun    = overrun_reg;

  // ---------------------------------------------------------------- echo transmitter
`ifdef HYPERTERM_RECV_ECHO_EN
  logic        tx_reg, tx_next;
  logic        tx_active_reg, tx_active_next;
  logic [15:0] tx_cnt_reg, tx_cnt_next;
  logic [3:0]  tx_bitn_reg, tx_bitn_next;
  logic [9:0]  tx_frame_reg, tx_frame_next;
  logic [7:0]  buf_reg, buf_next;
  logic        buf_full_reg, buf_full_next;
  logic        tx_tick;
  logic        tx_free;

  always_ff @(posedge clk_48) begin
    if (rst) begin
      tx_reg        <= 1'b1;
      tx_active_reg <= 1'b0;
      tx_cnt_reg    <= 16'd0;
      tx_bitn_reg   <= 4'd0;
      tx_frame_reg  <= 10'h3FF;
      buf_reg       <= 8'd0;
      buf_full_reg  <= 1'b0;
    end else begin
      tx_reg        <= tx_next;
      tx_active_reg <= tx_active_next;
      tx_cnt_reg    <= tx_cnt_next;
      tx_bitn_reg   <= tx_bitn_next;
      tx_frame_reg  <= tx_frame_next;
      buf_reg       <= buf_next;
      buf_full_reg  <= buf_full_next;
    end
  end

  // The last stop-bit tick counts as free so back-to-back bytes chain with no gap
  assign tx_tick = tx_active_reg && (tx_cnt_reg == DIV_LAST);
  assign tx_free = !tx_active_reg || (tx_tick && tx_bitn_reg == 4'd9);

  always_comb begin
    tx_next        = tx_reg;
    tx_active_next = tx_active_reg;
    tx_cnt_next    = tx_cnt_reg;
    tx_bitn_next   = tx_bitn_reg;
    tx_frame_next  = tx_frame_reg;
    buf_next       = buf_reg;
    buf_full_next  = buf_full_reg;
    if (tx_active_reg) begin
      if (tx_tick) begin
        tx_cnt_next = 16'd0;
        if (tx_bitn_reg == 4'd9) begin
          tx_active_next = 1'b0;
          tx_next        = 1'b1;
        end else begin
          tx_bitn_next  = tx_bitn_reg + 4'd1;
          tx_frame_next = {1'b1, tx_frame_reg[9:1]};
          tx_next       = tx_frame_reg[1];
        end
      end else begin
        tx_cnt_next = tx_cnt_reg + 16'd1;
      end
    end
    if (tx_free && (buf_full_reg || byte_done)) begin
      tx_frame_next  = {1'b1, (buf_full_reg ? buf_reg : shift_reg), 1'b0};
      tx_next        = 1'b0;
      tx_active_next = 1'b1;
      tx_cnt_next    = 16'd0;
      tx_bitn_next   = 4'd0;
      if (buf_full_reg) begin
        buf_full_next = byte_done;
        if (byte_done) buf_next = shift_reg;
      end
    end else if (byte_done && !buf_full_reg) begin
      buf_next      = shift_reg;
      buf_full_next = 1'b1;
    end
  end

  assign tx = tx_reg;
`else
  assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_hyperterm_recv.sv
// Directed bench for hyperterm_recv at BIT_DIV=20; echo checks run when HYPERTERM_RECV_ECHO_EN is defined.
`timescale 1ns/1ps
module tb_hyperterm_recv;

  localparam int DIV = 20;

  logic        clk_48 = 1'b0;
  logic        rst;
  logic        rx;
  logic        tx;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        frame_err;
  logic        hex_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hex_cnt = 0, frame_cnt = 0, ovr_cnt = 0, tx_low_cnt = 0;
  int rise_cyc = -1, frame_cyc = -1, tx_fall_cyc = -1;
  int start_cyc = 0;
  logic wv_prev = 1'b0, tx_prev = 1'b1;
  logic [15:0] acc_q[$];
  int base_hex, base_frame, base_ovr;

  hyperterm_recv #(.BIT_DIV(DIV)) dut (
    .clk_48     (clk_48),
    .rst        (rst),
    .rx         (rx),
    .tx         (tx),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_err  (frame_err),
    .hex_err    (hex_err),
    .overrun    (overrun)
  );

  always #5 clk_48 = ~clk_48;

  always @(posedge clk_48) cyc <= cyc + 1;

  // Event recorder sampled on the falling edge
  always @(negedge clk_48) begin
    hex_cnt    <= hex_cnt + int'(hex_err);
    frame_cnt  <= frame_cnt + int'(frame_err);
    ovr_cnt    <= ovr_cnt + int'(overrun);
    tx_low_cnt <= tx_low_cnt + int'(!tx);
    wv_prev    <= word_valid;
    tx_prev    <= tx;
    if (word_valid && !wv_prev) rise_cyc <= cyc;
    if (frame_err) frame_cyc <= cyc;
    if (!tx && tx_prev) tx_fall_cyc <= cyc;
    if (word_valid && word_ready) acc_q.push_back(word);
  end

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not finish within cycle budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk_48);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (DIV) @(negedge clk_48);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk_48);
    end
    rx = stop_bit;
    repeat (DIV) @(negedge clk_48);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_48);
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    word_ready = 1'b0;
    idle(4);
    rst = 1'b0;
    idle(1);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_word", 32'(word), 32'd0);
    check("reset_valid", 32'(word_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_hex_err", 32'(hex_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    idle(10);

    // single word, latency and handshake
    send_str("e7f9 ");
    check("t1_word", 32'(word), 32'hE7F9);
    check("t1_valid", 32'(word_valid), 32'd1);
    check("t1_rise_latency", 32'(rise_cyc - start_cyc), 32'd193);
    word_ready = 1'b1;
    idle(1);
    check("t1_valid_drop", 32'(word_valid), 32'd0);
    idle(5);

    // CR/LF delimiters, two words streamed
    acc_q.delete();
    base_hex = hex_cnt;
    send_str("A400\r\n1111 ");
    idle(3);
    check("t2_count", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      check("t2_word0", 32'(acc_q[0]), 32'hA400);
      check("t2_word1", 32'(acc_q[1]), 32'h1111);
    end
    check("t2_hex_err", 32'(hex_cnt - base_hex), 32'd0);

    // malformed tokens
    acc_q.delete();
    base_hex = hex_cnt;
    send_str("12 ");
    send_str("12g4 5 ");
    idle(3);
    check("t3_hex_err_pulses", 32'(hex_cnt - base_hex), 32'd3);
    check("t3_no_words", 32'(acc_q.size()), 32'd0);
    check("t3_valid", 32'(word_valid), 32'd0);

    // overrun while consumer stalls
    word_ready = 1'b0;
    base_ovr = ovr_cnt;
    send_str("0001 0002 ");
    idle(3);
    check("t4_held_word", 32'(word), 32'h0001);
    check("t4_valid", 32'(word_valid), 32'd1);
    check("t4_overrun_pulses", 32'(ovr_cnt - base_ovr), 32'd1);
    word_ready = 1'b1;
    idle(2);
    check("t4_drained", 32'(word_valid), 32'd0);
    idle(3);

    // framing error, line held low, then recovery
    acc_q.delete();
    base_hex = hex_cnt;
    base_frame = frame_cnt;
    send_byte(8'h66, 1'b0);
    idle(3 * DIV);
    rx = 1'b1;
    idle(2 * DIV);
    check("t5_frame_err_pulses", 32'(frame_cnt - base_frame), 32'd1);
    check("t5_frame_err_time", 32'(frame_cyc - start_cyc), 32'd193);
    check("t5_hex_err", 32'(hex_cnt - base_hex), 32'd0);
    check("t5_no_words", 32'(acc_q.size()), 32'd0);
    send_str("0000 ");
    idle(3);
    check("t5_recover_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() == 1) check("t5_recover_word", 32'(acc_q[0]), 32'h0000);

    // short glitch on idle line
    acc_q.delete();
    base_frame = frame_cnt;
    base_hex = hex_cnt;
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(3 * DIV);
    check("t6_glitch_frame_err", 32'(frame_cnt - base_frame), 32'd0);
    check("t6_glitch_hex_err", 32'(hex_cnt - base_hex), 32'd0);
    check("t6_glitch_words", 32'(acc_q.size()), 32'd0);

    // reset mid-frame discards partial token and clears output
    word_ready = 1'b0;
    send_str("beef ");
    check("t7_pre_word", 32'(word), 32'hBEEF);
    send_str("12");
    @(negedge clk_48);
    rx = 1'b0;
    idle(DIV);
    rx = 1'b1;
    idle(50);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t7_rst_valid", 32'(word_valid), 32'd0);
    check("t7_rst_word", 32'(word), 32'd0);
    check("t7_rst_tx", 32'(tx), 32'd1);
    idle(10 * DIV);
    base_hex = hex_cnt;
    word_ready = 1'b1;
    idle(2);
    acc_q.delete();
    send_str("3456 ");
    idle(3);
    check("t7_after_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() == 1) check("t7_after_word", 32'(acc_q[0]), 32'h3456);
    check("t7_after_hex_err", 32'(hex_cnt - base_hex), 32'd0);

`ifdef HYPERTERM_RECV_ECHO_EN
    begin
      logic [9:0] exp_frame;
      int target;
      idle(15 * DIV);
      exp_frame = {1'b1, 8'h63, 1'b0};
      send_byte(8'h63, 1'b1);
      check("t8_echo_start", 32'(tx_fall_cyc - start_cyc), 32'd193);
      for (int i = 0; i < 10; i++) begin
        target = start_cyc + 193 + DIV / 2 + DIV * i;
        while (cyc < target) @(negedge clk_48);
        check($sformatf("t8_echo_bit%0d", i), 32'(tx), 32'(exp_frame[i]));
      end
      idle(2 * DIV);
      word_ready = 1'b0;
      send_str("c0de ");
      check("t8_pre_word", 32'(word), 32'hC0DE);
      idle(3 * DIV);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("t8_rst_tx", 32'(tx), 32'd1);
      check("t8_rst_valid", 32'(word_valid), 32'd0);
    end
`else
    check("t8_tx_idle", 32'(tx_low_cnt), 32'd0);
`endif

    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
